// File: rtl/imem_loader_pkg.sv
// Shared state encoding and word/byte constants for the boot-time instruction loader.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        RUN
    } state_t;

    localparam int BYTES_PER_WORD  = 4;
    localparam int WORD_ADDR_SHIFT = 2;

    // Requests larger than the memory are trimmed so the word index can never wrap.
    function automatic int unsigned clamp_words(input int unsigned req,
                                                input int unsigned depth);
        return (req > depth) ? depth : req;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host-side byte stream, memory write port and core control of the instruction loader.
interface imem_loader_if #(
    parameter int CNT_W = 8
);
    logic             Start;
    logic [CNT_W-1:0] WordTotal;
    logic             ByteValid;
    logic [7:0]       ByteData;
    logic             ByteReady;
    logic             MemWrite;
    logic [31:0]      MemAddr;
    logic [31:0]      MemWriteData;
    logic             CoreRst;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, WordTotal, ByteValid, ByteData,
        input  ByteReady, MemWrite, MemAddr, MemWriteData, CoreRst, Busy, Done
    );

    modport slave (
        input  Start, WordTotal, ByteValid, ByteData,
        output ByteReady, MemWrite, MemAddr, MemWriteData, CoreRst, Busy, Done
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Collects four accepted bytes MSB-first into one 32-bit instruction word.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic        last,
    output logic        full,
    output logic [31:0] word_next
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic        full_q, full_d;

    assign word_next = {word_q[23:0], byte_in};
    assign last      = accept && (cnt_q == 2'(BYTES_PER_WORD - 1));
    assign full      = full_q;

    // NOTE: every variable gets a default before the branches; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        full_d = full_q;
        if (clear) begin
            cnt_d  = '0;
            word_d = '0;
            full_d = 1'b0;
        end else if (accept) begin
            cnt_d  = cnt_q + 2'd1;
            word_d = word_next;
            full_d = full_q | last;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt_q  <= '0;
            word_q <= '0;
            full_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
            full_q <= full_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: packs a byte stream big-endian into words, writes them to instruction
// memory from address 0, and holds the core in reset until the last word has landed.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int CNT_W       = 8
) (
    input  logic         Clk,
    input  logic         Rst,
    imem_loader_if.slave bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] index_q, index_d;
    logic             byte_ready_q, byte_ready_d;
    logic             mem_write_q, mem_write_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             core_rst_q, core_rst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             pk_clear;
    logic             pk_accept;
    logic             pk_last;
    logic             pk_full;
    logic [31:0]      pk_word_next;
    logic [CNT_W-1:0] start_total;

    assign pk_accept   = bus.ByteValid && byte_ready_q;
    assign start_total = CNT_W'(clamp_words(32'(bus.WordTotal), DEPTH_WORDS));

    byte_packer u_packer (
        .Clk       (Clk),
        .Rst       (Rst),
        .clear     (pk_clear),
        .accept    (pk_accept),
        .byte_in   (bus.ByteData),
        .last      (pk_last),
        .full      (pk_full),
        .word_next (pk_word_next)
    );

    always_comb begin
        state_d     = state_q;
        total_d     = total_q;
        index_d     = index_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        // A completed word is flushed from the packer during its WRITE cycle.
        pk_clear    = pk_full;

        case (state_q)
            IDLE, RUN: begin
                if (bus.Start) begin
                    total_d  = start_total;
                    index_d  = '0;
                    pk_clear = 1'b1;
                    state_d  = (start_total == '0) ? RUN : LOAD;
                end
            end
            LOAD: begin
                if (pk_last) begin
                    state_d     = WRITE;
                    mem_addr_d  = 32'(index_q) << WORD_ADDR_SHIFT;
                    mem_wdata_d = pk_word_next;
                end
            end
            WRITE: begin
                index_d = index_q + 1'b1;
                state_d = (index_d == total_q) ? RUN : LOAD;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they line up with it once registered.
        byte_ready_d = (state_d == LOAD);
        mem_write_d  = (state_d == WRITE);
        busy_d       = (state_d == LOAD) || (state_d == WRITE);
        done_d       = (state_d == RUN);
        core_rst_d   = (state_d != RUN);
    end

    // CoreRst resets high so the core is held the instant Rst rises, before any clock.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= IDLE;
            total_q      <= '0;
            index_q      <= '0;
            byte_ready_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_rst_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            total_q      <= total_d;
            index_q      <= index_d;
            byte_ready_q <= byte_ready_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_rst_q   <= core_rst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.ByteReady    = byte_ready_q;
    assign bus.MemWrite     = mem_write_q;
    assign bus.MemAddr      = mem_addr_q;
    assign bus.MemWriteData = mem_wdata_q;
    assign bus.CoreRst      = core_rst_q;
    assign bus.Busy         = busy_q;
    assign bus.Done         = done_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench: directed and random loads compared against a byte-queue reference model.
module tb_imem_loader;

    localparam int DEPTH = 128;
    localparam int CNT_W = 8;

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    imem_loader_if #(.CNT_W(CNT_W)) bus ();

    imem_loader #(.DEPTH_WORDS(DEPTH), .CNT_W(CNT_W)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [7:0]  stim[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          acc_cyc[$];
    int          rel_cyc[$];
    logic        core_rst_prev;

    always @(posedge Clk) cyc <= cyc + 1;

    // Passive monitor, sampled mid-cycle.
    always @(negedge Clk) begin
        if (bus.MemWrite === 1'b1) begin
            wr_addr.push_back(bus.MemAddr);
            wr_data.push_back(bus.MemWriteData);
            wr_cyc.push_back(cyc);
        end
        if (bus.ByteValid === 1'b1 && bus.ByteReady === 1'b1) acc_cyc.push_back(cyc);
        if (core_rst_prev === 1'b1 && bus.CoreRst === 1'b0) rel_cyc.push_back(cyc);
        core_rst_prev <= bus.CoreRst;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        acc_cyc.delete();
        rel_cyc.delete();
    endtask

    task automatic fill_stim(input int n);
        stim.delete();
        repeat (n) stim.push_back(8'($urandom));
    endtask

    // All tasks start and end just after a rising edge.
    task automatic do_start(input int total);
        bus.Start     = 1'b1;
        bus.WordTotal = CNT_W'(total);
        @(posedge Clk); #1;
        bus.Start     = 1'b0;
        bus.WordTotal = CNT_W'($urandom);
    endtask

    // mode 0: back-to-back, 1: valid every other cycle, 2: random valid.
    // noise drives random Start/WordTotal, which the loader must ignore mid-load.
    task automatic feed(input int n, input int mode, input bit noise);
        int   sent = 0;
        int   t    = 0;
        logic v;
        while (sent < n && t < 40 * n + 40) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (t[0] == 1'b0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.ByteValid = v;
            bus.ByteData  = v ? stim[sent] : 8'($urandom);
            if (noise) begin
                bus.Start     = 1'($urandom_range(0, 1));
                bus.WordTotal = CNT_W'($urandom);
            end
            @(negedge Clk);
            if (bus.ByteValid && bus.ByteReady) sent++;
            @(posedge Clk); #1;
            t++;
        end
        bus.ByteValid = 1'b0;
        bus.Start     = 1'b0;
        check("feed_bytes_accepted", sent, n);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (bus.Done !== 1'b1 && k < budget) begin
            @(posedge Clk); #1;
            k++;
        end
        check("done_within_budget", bus.Done, 1'b1);
        @(negedge Clk);
        @(posedge Clk); #1;
    endtask

    // Reference: word i is stim[4i..4i+3] MSB-first at byte address 4i, for min(req, DEPTH) words.
    task automatic check_load(input string tag, input int req);
        int n = (req < DEPTH) ? req : DEPTH;
        check({tag, "_nwrites"}, wr_addr.size(), n);
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            check({tag, "_addr"}, wr_addr[i], 4 * i);
            check({tag, "_data"}, wr_data[i],
                  {stim[4*i], stim[4*i+1], stim[4*i+2], stim[4*i+3]});
        end
        check({tag, "_release_count"}, rel_cyc.size(), 1);
        if (rel_cyc.size() > 0 && wr_cyc.size() > 0)
            check({tag, "_release_cycle"}, rel_cyc[0], wr_cyc[wr_cyc.size()-1] + 1);
        check({tag, "_done"}, bus.Done, 1'b1);
        check({tag, "_core_rst"}, bus.CoreRst, 1'b0);
        check({tag, "_busy"}, bus.Busy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_core_rst"}, bus.CoreRst, 1'b1);
        check({tag, "_byte_ready"}, bus.ByteReady, 1'b0);
        check({tag, "_mem_write"}, bus.MemWrite, 1'b0);
        check({tag, "_mem_addr"}, bus.MemAddr, 32'h0);
        check({tag, "_mem_wdata"}, bus.MemWriteData, 32'h0);
        check({tag, "_busy"}, bus.Busy, 1'b0);
        check({tag, "_done"}, bus.Done, 1'b0);
    endtask

    initial begin
        bus.Start     = 1'b0;
        bus.WordTotal = '0;
        bus.ByteValid = 1'b0;
        bus.ByteData  = '0;
        Rst           = 1'b1;

        // Reset values, then idle with the core held until Start.
        repeat (2) @(posedge Clk); #1;
        check_reset_outputs("reset");
        Rst = 1'b0;
        repeat (3) @(posedge Clk); #1;
        check_reset_outputs("idle_after_reset");

        // Two words back-to-back.
        clear_log();
        stim = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h22, 8'h00, 8'h08};
        do_start(2);
        feed(8, 0, 1'b0);
        wait_done(20);
        check_load("b2b", 2);
        check("b2b_accepts", acc_cyc.size(), 8);
        if (acc_cyc.size() > 0 && wr_cyc.size() == 2) begin
            check("b2b_first_accept_to_last_write", wr_cyc[1] - acc_cyc[0], 9);
            check("b2b_word_spacing", wr_cyc[1] - wr_cyc[0], 5);
        end

        // Same load restarted from RUN with ByteValid toggling.
        clear_log();
        do_start(2);
        feed(8, 1, 1'b0);
        wait_done(20);
        check_load("toggle", 2);
        check("toggle_accepts", acc_cyc.size(), 8);

        // Zero-word load straight from IDLE.
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(posedge Clk); #1;
        clear_log();
        check("zero_pre_done", bus.Done, 1'b0);
        do_start(0);
        check("zero_done_next_cycle", bus.Done, 1'b1);
        check("zero_core_rst_next_cycle", bus.CoreRst, 1'b0);
        check("zero_busy", bus.Busy, 1'b0);
        repeat (4) @(posedge Clk); #1;
        check("zero_no_writes", wr_addr.size(), 0);

        // Oversized request is clamped to DEPTH words; Start noise during the load.
        clear_log();
        fill_stim(4 * DEPTH);
        do_start(200);
        feed(4 * DEPTH, 2, 1'b1);
        wait_done(20);
        check_load("clamp", 200);
        if (wr_addr.size() > 0) check("clamp_last_addr", wr_addr[wr_addr.size()-1], 32'h1FC);
        // Bytes offered in RUN are not consumed.
        bus.ByteValid = 1'b1;
        bus.ByteData  = 8'hFF;
        repeat (4) @(posedge Clk); #1;
        @(negedge Clk);
        check("run_byte_ready_low", bus.ByteReady, 1'b0);
        @(posedge Clk); #1;
        bus.ByteValid = 1'b0;
        check("run_no_accepts", acc_cyc.size(), 4 * DEPTH);
        check("run_no_extra_writes", wr_addr.size(), DEPTH);

        // Reset after two bytes of the second word.
        clear_log();
        fill_stim(8);
        do_start(2);
        feed(6, 0, 1'b0);
        Rst = 1'b1;
        #2;
        check_reset_outputs("midload_rst");
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(posedge Clk); #1;
        check("midload_idle_core_rst", bus.CoreRst, 1'b1);
        clear_log();
        fill_stim(4);
        do_start(1);
        feed(4, 2, 1'b0);
        wait_done(20);
        check_load("after_rst", 1);

        // Restart from RUN: CoreRst and Busy rise together.
        clear_log();
        fill_stim(4);
        @(negedge Clk);
        check("restart_pre_core_rst", bus.CoreRst, 1'b0);
        check("restart_pre_busy", bus.Busy, 1'b0);
        @(posedge Clk); #1;
        do_start(1);
        @(negedge Clk);
        check("restart_core_rst_with_busy", bus.CoreRst, 1'b1);
        check("restart_busy", bus.Busy, 1'b1);
        @(posedge Clk); #1;
        feed(4, 0, 1'b0);
        wait_done(20);
        check_load("restart", 1);

        // Randomized loads.
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(1, 6);
            clear_log();
            fill_stim(4 * n);
            do_start(n);
            feed(4 * n, $urandom_range(0, 2), 1'b1);
            wait_done(20);
            check_load("random", n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
